// File: rtl/pool_pkg.sv
// Shared definitions for the pooling-layer transmitters: lane geometry,
// TX state encoding and the per-lane signed max used by the pooling datapath.
package pool_pkg;

  localparam int LANE_W      = 16;
  localparam int LANE_SHIFT  = 4;
  localparam int CHANNEL_NUM = 8;

  typedef enum logic [1:0] {
    TX_IDLE   = 2'd0,
    TX_STROBE = 2'd1,
    TX_GAP    = 2'd2
  } tx_state_t;

  // Two's complement max of one lane; on a tie both operands are identical.
  function automatic logic [LANE_W-1:0] smax(input logic [LANE_W-1:0] a,
                                             input logic [LANE_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

endpackage

// File: rtl/sync_fifo_reg.sv
// Small synchronous FIFO with register storage and a head word that is
// always readable. A push against a full FIFO is refused unless a pop
// frees an entry in the same cycle; a refused push is flagged on o_drop.
module sync_fifo_reg #(
  parameter int WIDTH   = 128,
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);

  localparam logic [DEPTH_W:0] FULL_CNT = (DEPTH_W+1)'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [DEPTH_W-1:0] r_wr_ptr;
  logic [DEPTH_W-1:0] r_rd_ptr;
  logic [DEPTH_W:0]   r_count;
  logic               w_pop;
  logic               w_push;

  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_drop  = i_push & ~w_push;
  assign o_rdata = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pool2_max_tx.sv
// Stride-2 2x2 max pooling over a raster stream, feeding a paced strobe
// transmitter that hands one pooled pixel at a time to the line buffer.
//
// TX state | meaning
// IDLE     | waiting for a pooled pixel; pops and raises start when one exists
// STROBE   | start high for this single cycle, gap timer loaded
// GAP      | gap timer counting down so strobes stay min_gap apart
module pool2_max_tx
  import pool_pkg::*;
#(
  parameter int bits         = LANE_W,
  parameter int bits_shift   = LANE_SHIFT,
  parameter int channel_num  = CHANNEL_NUM,
  parameter int in_length    = 26,
  parameter int in_height    = 26,
  parameter int length_2     = 5,
  parameter int fifo_depth   = 4,
  parameter int fifo_depth_2 = 2,
  parameter int min_gap      = 4
) (
  input  logic                                 clk_in,
  input  logic                                 rst_n,
  input  logic                                 in_valid,
  input  logic [(channel_num<<bits_shift)-1:0] data_in,
  output logic                                 start,
  output logic [(channel_num<<bits_shift)-1:0] data_out,
  output logic                                 frame_done,
  output logic                                 overflow,
  output logic                                 busy
);

  localparam int BUS_W     = channel_num << bits_shift;
  localparam int HALF_LEN  = in_length / 2;
  localparam int OUT_TOTAL = (in_length / 2) * (in_height / 2);
  localparam int OUT_W     = $clog2(OUT_TOTAL);
  localparam int GAP_W     = $clog2(min_gap);

  localparam logic [length_2-1:0] COL_LAST = length_2'(in_length - 1);
  localparam logic [length_2-1:0] ROW_LAST = length_2'(in_height - 1);
  localparam logic [OUT_W-1:0]    OUT_LAST = OUT_W'(OUT_TOTAL - 1);
  localparam logic [GAP_W-1:0]    GAP_LOAD = GAP_W'(min_gap - 2);

  logic [length_2-1:0] r_col;
  logic [length_2-1:0] r_row;
  logic [length_2-2:0] w_rb_idx;
  logic [BUS_W-1:0]    r_hold;
  logic [BUS_W-1:0]    r_rowbuf [HALF_LEN];
  logic [BUS_W-1:0]    w_rb_rd;
  logic [BUS_W-1:0]    w_hmax;
  logic [BUS_W-1:0]    w_pool_max;
  logic [BUS_W-1:0]    r_pooled;
  logic                r_pool_vld;

  logic [BUS_W-1:0]    w_fifo_rdata;
  logic                w_fifo_full;
  logic                w_fifo_empty;
  logic                w_fifo_drop;

  tx_state_t           r_state;
  tx_state_t           w_state_nxt;
  logic                w_pop;
  logic [GAP_W-1:0]    r_gap_cnt;
  logic [OUT_W-1:0]    r_out_cnt;

  assign w_rb_idx = r_col[length_2-1:1];
  assign w_rb_rd  = r_rowbuf[w_rb_idx];

  for (genvar k = 0; k < channel_num; k++) begin : g_lane
    assign w_hmax[k*bits +: bits]     = smax(r_hold[k*bits +: bits], data_in[k*bits +: bits]);
    assign w_pool_max[k*bits +: bits] = smax(w_rb_rd[k*bits +: bits], w_hmax[k*bits +: bits]);
  end

  // Raster position of the next input beat; wraps into a new frame.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (in_valid) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Horizontal pair max, parked in the row buffer on even rows and merged
  // with the buffered pair on odd rows to form the pooled pixel.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_hold     <= '0;
      r_pooled   <= '0;
      r_pool_vld <= 1'b0;
      for (int i = 0; i < HALF_LEN; i++) r_rowbuf[i] <= '0;
    end else begin
      r_pool_vld <= 1'b0;
      if (in_valid) begin
        if (!r_col[0]) begin
          r_hold <= data_in;
        end else if (!r_row[0]) begin
          r_rowbuf[w_rb_idx] <= w_hmax;
        end else begin
          r_pooled   <= w_pool_max;
          r_pool_vld <= 1'b1;
        end
      end
    end
  end

  sync_fifo_reg #(
    .WIDTH   (BUS_W),
    .DEPTH   (fifo_depth),
    .DEPTH_W (fifo_depth_2)
  ) u_fifo (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .i_push  (r_pool_vld),
    .i_wdata (r_pooled),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_drop  (w_fifo_drop)
  );

  // TX next state and pop request.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    case (r_state)
      TX_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = TX_STROBE;
        end
      end
      TX_STROBE: w_state_nxt = TX_GAP;
      // Leave as the timer reaches zero so the next pop lands exactly min_gap after the last.
      TX_GAP:    if (r_gap_cnt == GAP_W'(1)) w_state_nxt = TX_IDLE;
      default:   w_state_nxt = TX_IDLE;
    endcase
  end

  // TX state register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) r_state <= TX_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Inter-strobe gap down-counter.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)                    r_gap_cnt <= '0;
    else if (r_state == TX_STROBE) r_gap_cnt <= GAP_LOAD;
    else if (r_state == TX_GAP)    r_gap_cnt <= r_gap_cnt - 1'b1;
  end

  // Output strobe, data and end-of-frame marker; data_out moves only on a pop.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      start      <= 1'b0;
      data_out   <= '0;
      frame_done <= 1'b0;
      r_out_cnt  <= '0;
    end else begin
      start      <= w_pop;
      frame_done <= 1'b0;
      if (w_pop) begin
        data_out <= w_fifo_rdata;
        if (r_out_cnt == OUT_LAST) begin
          r_out_cnt  <= '0;
          frame_done <= 1'b1;
        end else begin
          r_out_cnt <= r_out_cnt + 1'b1;
        end
      end
    end
  end

  // Sticky record of any pooled pixel lost to a full FIFO.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n)           overflow <= 1'b0;
    else if (w_fifo_drop) overflow <= 1'b1;
  end

  assign busy = ~w_fifo_empty | (r_state != TX_IDLE);

endmodule

// File: tb/tb_pool2_max_tx.sv
module tb_pool2_max_tx;

  localparam int BW      = 128;
  localparam int LEN     = 26;
  localparam int HGT     = 26;
  localparam int NPOOL   = 169;
  localparam int DEPTH   = 4;
  localparam int MIN_GAP = 4;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic          in_valid = 1'b0;
  logic [BW-1:0] data_in  = '0;
  logic          start;
  logic [BW-1:0] data_out;
  logic          frame_done;
  logic          overflow;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  pool2_max_tx dut (
    .clk_in     (clk_in),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .data_in    (data_in),
    .start      (start),
    .data_out   (data_out),
    .frame_done (frame_done),
    .overflow   (overflow),
    .busy       (busy)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- image patterns and pooled reference ----------------
  int pat = 0;

  function automatic logic signed [15:0] pix_lane(input int p, input int r, input int c, input int k);
    int unsigned h;
    if (p == 0) return 16'(r * LEN + c);
    if (p == 1) begin
      h = 32'(r * 1000 + c * 37 + k * 7001 + 13) * 32'h9E3779B1;
      return h[31:16];
    end
    if (r < 2 && c < 2) begin
      if (k == 0) begin
        case (r * 2 + c)
          0: return -16'sd5;
          1: return -16'sd3;
          2: return -16'sd7;
          default: return -16'sd1;
        endcase
      end
      if (k == 1) begin
        case (r * 2 + c)
          0: return 16'sd100;
          1: return -16'sd100;
          2: return 16'sd0;
          default: return 16'sh8000;
        endcase
      end
    end
    return 16'sd0;
  endfunction

  function automatic logic [BW-1:0] pix(input int p, input int r, input int c);
    logic [BW-1:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = pix_lane(p, r, c, k);
    return v;
  endfunction

  function automatic logic [BW-1:0] pooled(input int p, input int pr, input int pc);
    logic [BW-1:0]      v;
    logic signed [15:0] m;
    logic signed [15:0] x;
    for (int k = 0; k < 8; k++) begin
      m = pix_lane(p, 2*pr, 2*pc, k);
      for (int d = 1; d < 4; d++) begin
        x = pix_lane(p, 2*pr + d/2, 2*pc + d%2, k);
        if (x > m) m = x;
      end
      v[k*16 +: 16] = m;
    end
    return v;
  endfunction

  // ---------------- cycle model and compare process ----------------
  logic [BW-1:0] mq[$];
  logic [BW-1:0] m_data;
  logic          m_start, m_done, m_ovf, m_busy;
  bit            pend_v, m_pop;
  logic [BW-1:0] pend_d;
  int            m_beat, m_outcnt, m_edge, m_last_pop, mr, mc;
  int            cyc = 0;

  logic [BW-1:0] cap[$];
  int            cap_cyc[$];
  int            done_at[$];

  always @(negedge clk_in) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_start", start, 0);
      chk("rst_data", data_out, 0);
      chk("rst_done", frame_done, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_busy", busy, 0);
      mq.delete();
      m_data = '0; m_start = 0; m_done = 0; m_ovf = 0; m_busy = 0;
      pend_v = 0; pend_d = '0;
      m_beat = 0; m_outcnt = 0; m_edge = 0; m_last_pop = -100;
    end else begin
      chk("start", start, m_start);
      chk("data_out", data_out, m_data);
      chk("frame_done", frame_done, m_done);
      chk("overflow", overflow, m_ovf);
      chk("busy", busy, m_busy);
      if (start === 1'b1) begin
        cap.push_back(data_out);
        cap_cyc.push_back(cyc);
        if (frame_done === 1'b1) done_at.push_back(cap.size());
      end
      // effect of the coming clock edge
      m_pop   = (mq.size() > 0) && (m_edge - m_last_pop >= MIN_GAP);
      m_start = m_pop;
      m_done  = 0;
      if (m_pop) begin
        m_data     = mq.pop_front();
        m_last_pop = m_edge;
        if (m_outcnt == NPOOL - 1) begin
          m_done   = 1;
          m_outcnt = 0;
        end else m_outcnt++;
      end
      if (pend_v) begin
        if (mq.size() < DEPTH) mq.push_back(pend_d);
        else m_ovf = 1;
      end
      pend_v = 0;
      if (in_valid) begin
        mr = m_beat / LEN;
        mc = m_beat % LEN;
        if (mr % 2 == 1 && mc % 2 == 1) begin
          pend_v = 1;
          pend_d = pooled(pat, mr / 2, mc / 2);
        end
        m_beat = (m_beat == LEN * HGT - 1) ? 0 : m_beat + 1;
      end
      m_busy = (mq.size() > 0) || (m_edge - m_last_pop < MIN_GAP - 1);
      m_edge++;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic beat(input logic [BW-1:0] d, input int idle);
    in_valid = 1'b1;
    data_in  = d;
    @(posedge clk_in); #1;
    in_valid = 1'b0;
    for (int i = 0; i < idle; i++) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic send_frame(input int p, input int idle, input int nbeats);
    for (int b = 0; b < nbeats; b++) beat(pix(p, b / LEN, b % LEN), idle);
  endtask

  task automatic drain();
    int n;
    n = 0;
    repeat (3) begin @(posedge clk_in); #1; end
    while (busy && n < 400) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("drain_timeout", busy, 0);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk_in); #1; end
    rst_n = 1'b1;
  endtask

  task automatic clear_caps();
    cap.delete();
    cap_cyc.delete();
    done_at.delete();
  endtask

  task automatic check_spacing(input string tag, output int min_d);
    min_d = 1000;
    for (int i = 1; i < cap_cyc.size(); i++)
      if (cap_cyc[i] - cap_cyc[i-1] < min_d) min_d = cap_cyc[i] - cap_cyc[i-1];
    chk_int({tag, "_min_spacing_ok"}, int'(min_d >= MIN_GAP), 1);
  endtask

  task automatic check_ramp(input string tag);
    logic [BW-1:0] t;
    int v;
    chk_int({tag, "_count"}, cap.size(), NPOOL);
    chk_int({tag, "_done_cnt"}, done_at.size(), 1);
    if (done_at.size() > 0) chk_int({tag, "_done_pos"}, done_at[0], NPOOL);
    if (cap.size() == NPOOL) begin
      t = cap[0];   chk_int({tag, "_first"}, int'($signed(t[15:0])), 27);
      t = cap[13];  chk_int({tag, "_14th"},  int'($signed(t[15:0])), 79);
      t = cap[168]; chk_int({tag, "_last"},  int'($signed(t[15:0])), 675);
      for (int k = 0; k < NPOOL; k++) begin
        v = (2 * (k / 13) + 1) * LEN + 2 * (k % 13) + 1;
        chk({tag, "_pix"}, cap[k], {8{16'(v)}});
      end
    end
  endtask

  // ---------------- directed scenarios ----------------
  int            min_d;
  logic [BW-1:0] t0;

  initial begin
    rst_n = 1'b0;
    repeat (3) begin @(posedge clk_in); #1; end
    chk("init_start", start, 0);
    chk("init_data", data_out, 0);
    chk("init_done", frame_done, 0);
    chk("init_ovf", overflow, 0);
    chk("init_busy", busy, 0);
    rst_n = 1'b1;

    // ramp frame, paced so nothing is dropped
    pat = 0;
    clear_caps();
    send_frame(0, 1, LEN * HGT);
    drain();
    check_ramp("ramp");
    check_spacing("ramp", min_d);
    chk("ramp_no_ovf", overflow, 0);

    // signed max and latency on the first window, sparse input
    reset_pulse();
    pat = 2;
    clear_caps();
    for (int b = 0; b < 2 * LEN; b++) begin
      if (b == LEN + 1) begin
        in_valid = 1'b1;
        data_in  = pix(2, 1, 1);
        @(posedge clk_in); #1;
        in_valid = 1'b0;
        chk("lat_edge0", start, 0);
        @(posedge clk_in); #1;
        chk("lat_edge1", start, 0);
        @(posedge clk_in); #1;
        chk("lat_edge2", start, 1);
        t0 = data_out;
        chk("signed_max", t0, {96'h0, 16'h0064, 16'hFFFF});
      end else begin
        beat(pix(2, b / LEN, b % LEN), 3);
      end
    end
    drain();
    chk_int("signed_count", cap.size(), 13);

    // continuous input: overflow must appear and stick, pacing unchanged
    reset_pulse();
    pat = 1;
    clear_caps();
    chk("ovf_clear", overflow, 0);
    send_frame(1, 0, LEN * HGT);
    drain();
    chk("ovf_set", overflow, 1);
    chk_int("ovf_dropped", int'(cap.size() < NPOOL), 1);
    check_spacing("ovf", min_d);
    chk_int("ovf_spacing_exact", min_d, MIN_GAP);
    repeat (20) begin @(posedge clk_in); #1; end
    chk("ovf_sticky", overflow, 1);

    // reset in the middle of row 15, then a clean ramp frame
    reset_pulse();
    pat = 0;
    send_frame(0, 1, 15 * LEN + 10);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_start", start, 0);
    chk("mid_rst_data", data_out, 0);
    chk("mid_rst_done", frame_done, 0);
    chk("mid_rst_ovf", overflow, 0);
    chk("mid_rst_busy", busy, 0);
    @(posedge clk_in); #1;
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    clear_caps();
    send_frame(0, 1, LEN * HGT);
    drain();
    check_ramp("rerun");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
